// File: rtl/mips_regfile_param_pkg.sv
// Shared constants and helpers for the parametrised MIPS register file.
// The optional REGFILE_BYPASS_EN build is handled in mips_regfile_param.sv.
package mips_regfile_param_pkg;

  localparam int unsigned MIPS_NUM_REGS = 32;
  localparam int unsigned MIPS_REG_AW   = 5;
  localparam int unsigned MIPS_WORD     = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

  localparam int unsigned     WR_COUNT_W   = 16;
  localparam logic [15:0]     WR_COUNT_MAX = 16'hFFFF;

  // Saturating increment: the count sticks at its maximum instead of wrapping.
  function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] value);
    return (value == WR_COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mips_regfile_param_mux.sv
// Generic N:1 multiplexer over a flattened bus; entry i lives at [i*WIDTH +: WIDTH].
module mux_nbits_nto1 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 32,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   data_out
);

  always_comb begin
    data_out = data_in[sel*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/mips_regfile_param.sv
// Parametrised MIPS register file: NUM_RD combinational read ports, one write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read lanes.
module mips_regfile_param
  import mips_regfile_param_pkg::*;
#(
  parameter int unsigned WIDTH    = MIPS_WORD,
  parameter int unsigned DEPTH    = MIPS_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [WR_COUNT_W-1:0]    wr_count
);

  logic [WIDTH-1:0]      regs_q [DEPTH];
  logic [WIDTH-1:0]      regs_d [DEPTH];
  logic [WR_COUNT_W-1:0] wr_count_q;
  logic [WR_COUNT_W-1:0] wr_count_d;
  logic [DEPTH*WIDTH-1:0] regs_flat;
  logic                  wr_commit;

  // A write to the hardwired zero register is dropped and not counted.
  assign wr_commit = wr_en && !(ZERO_REG && (wr_addr == ADDR_W'(REG_ZERO)));

  // NOTE: every variable assigned in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_commit) begin
      regs_d[wr_addr] = wr_data;
      wr_count_d      = sat_inc(wr_count_q);
    end
  end

  // NOTE: the register array is reset explicitly because software relies on
  // every register reading 0 after reset; this keeps it out of plain RAM macros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    if (ZERO_REG) regs_flat[WIDTH-1:0] = '0;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [WIDTH-1:0]  stored;
    logic [ADDR_W-1:0] lane_addr;

    assign lane_addr = rd_addr[k*ADDR_W +: ADDR_W];

    mux_nbits_nto1 #(
      .WIDTH (WIDTH),
      .N     (DEPTH),
      .SEL_W (ADDR_W)
    ) u_mux (
      .data_in  (regs_flat),
      .sel      (lane_addr),
      .data_out (stored)
    );

`ifdef REGFILE_BYPASS_EN
    // Write-through so decode sees a value being written back this cycle.
    logic hit;
    assign hit = rst_n && wr_commit && (lane_addr == wr_addr);
    assign rd_data[k*WIDTH +: WIDTH] = hit ? wr_data : stored;
`else
    assign rd_data[k*WIDTH +: WIDTH] = stored;
`endif
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mips_regfile_param.sv
// Directed self-checking bench: default 32x32 instance plus a 16-bit, 8-entry,
// 3-read-port instance without the zero register.
module tb_mips_regfile_param;
  import mips_regfile_param_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [15:0] a_wr_count;

  logic        b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic [8:0]  b_rd_addr;
  logic [47:0] b_rd_data;
  logic [15:0] b_wr_count;

  int n_cmp = 0;
  int n_err = 0;

  mips_regfile_param u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (a_wr_en),
    .wr_addr  (a_wr_addr),
    .wr_data  (a_wr_data),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .wr_count (a_wr_count)
  );

  mips_regfile_param #(
    .WIDTH    (16),
    .DEPTH    (8),
    .NUM_RD   (3),
    .ZERO_REG (1'b0)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr),
    .wr_data  (b_wr_data),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .wr_count (b_wr_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [4:0] addr, input logic [31:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    step();
    a_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h1234_5678;
    b_wr_en = 1'b1; b_wr_addr = 3'd3; b_wr_data = 16'h1234;
    a_rd_addr = '0; b_rd_addr = '0;
    step();
    step();
    rst_n = 1'b1; a_wr_en = 1'b0; b_wr_en = 1'b0;
    a_rd_addr = {5'd31, 5'd7};
    b_rd_addr = {3'd7, 3'd3, 3'd0};
    #1;
    n_cmp++;
    if (a_rd_data !== 64'd0) begin
      n_err++; $display("FAIL reset_rd_a got=%h exp=%h", a_rd_data, 64'd0);
    end
    n_cmp++;
    if (a_wr_count !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt_a got=%0d exp=0", a_wr_count);
    end
    n_cmp++;
    if (b_rd_data !== 48'd0) begin
      n_err++; $display("FAIL reset_rd_b got=%h exp=%h", b_rd_data, 48'd0);
    end
    n_cmp++;
    if (b_wr_count !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt_b got=%0d exp=0", b_wr_count);
    end
  endtask

  task automatic test_write_read();
    a_write(5'd25, 32'd345);
    a_rd_addr = {5'd25, 5'd25};
    #1;
    n_cmp++;
    if (a_rd_data !== {32'd345, 32'd345}) begin
      n_err++; $display("FAIL wr_rd_r25 got=%h exp=%h", a_rd_data, {32'd345, 32'd345});
    end
    n_cmp++;
    if (a_wr_count !== 16'd1) begin
      n_err++; $display("FAIL wr_rd_cnt got=%0d exp=1", a_wr_count);
    end
    a_write(5'(REG_SP), 32'h7FFF_FFF0);
    a_write(5'(REG_RA), 32'h0040_0020);
    a_rd_addr = {5'(REG_RA), 5'(REG_SP)};
    #1;
    n_cmp++;
    if (a_rd_data !== {32'h0040_0020, 32'h7FFF_FFF0}) begin
      n_err++; $display("FAIL wr_rd_sp_ra got=%h exp=%h", a_rd_data, {32'h0040_0020, 32'h7FFF_FFF0});
    end
    n_cmp++;
    if (a_wr_count !== 16'd3) begin
      n_err++; $display("FAIL wr_rd_cnt3 got=%0d exp=3", a_wr_count);
    end
  endtask

  task automatic test_zero_reg();
    a_wr_en = 1'b1; a_wr_addr = 5'(REG_ZERO); a_wr_data = 32'hDEAD_BEEF;
    a_rd_addr = {5'd0, 5'd0};
    #1;
    n_cmp++;
    if (a_rd_data !== 64'd0) begin
      n_err++; $display("FAIL zero_same_cycle got=%h exp=0", a_rd_data);
    end
    step();
    a_wr_en = 1'b0;
    #1;
    n_cmp++;
    if (a_rd_data !== 64'd0) begin
      n_err++; $display("FAIL zero_after got=%h exp=0", a_rd_data);
    end
    n_cmp++;
    if (a_wr_count !== 16'd3) begin
      n_err++; $display("FAIL zero_cnt got=%0d exp=3", a_wr_count);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
    a_write(5'd6, 32'd35);
    a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'd276;
    a_rd_addr = {5'd25, 5'd6};
`ifdef REGFILE_BYPASS_EN
    exp_now = 32'd276;
`else
    exp_now = 32'd35;
`endif
    #1;
    n_cmp++;
    if (a_rd_data !== {32'd345, exp_now}) begin
      n_err++; $display("FAIL same_cycle_now got=%h exp=%h", a_rd_data, {32'd345, exp_now});
    end
    step();
    a_wr_en = 1'b0;
    #1;
    n_cmp++;
    if (a_rd_data !== {32'd345, 32'd276}) begin
      n_err++; $display("FAIL same_cycle_next got=%h exp=%h", a_rd_data, {32'd345, 32'd276});
    end
    n_cmp++;
    if (a_wr_count !== 16'd5) begin
      n_err++; $display("FAIL same_cycle_cnt got=%0d exp=5", a_wr_count);
    end
  endtask

  task automatic test_back_to_back();
    a_wr_en = 1'b1;
    a_wr_addr = 5'd1; a_wr_data = 32'd11; step();
    a_wr_addr = 5'd2; a_wr_data = 32'd22; step();
    a_wr_addr = 5'd3; a_wr_data = 32'd33; step();
    a_wr_en = 1'b0;
    a_rd_addr = {5'd3, 5'd1};
    #1;
    n_cmp++;
    if (a_rd_data !== {32'd33, 32'd11}) begin
      n_err++; $display("FAIL b2b_1_3 got=%h exp=%h", a_rd_data, {32'd33, 32'd11});
    end
    a_rd_addr = {5'd6, 5'd2};
    #1;
    n_cmp++;
    if (a_rd_data !== {32'd276, 32'd22}) begin
      n_err++; $display("FAIL b2b_2_6 got=%h exp=%h", a_rd_data, {32'd276, 32'd22});
    end
    n_cmp++;
    if (a_wr_count !== 16'd8) begin
      n_err++; $display("FAIL b2b_cnt got=%0d exp=8", a_wr_count);
    end
  endtask

  task automatic test_reset_mid();
    a_write(5'd16, 32'd276);
    rst_n = 1'b0;
    a_wr_en = 1'b1; a_wr_addr = 5'd16; a_wr_data = 32'd99;
    step();
    rst_n = 1'b1; a_wr_en = 1'b0;
    a_rd_addr = {5'd25, 5'd16};
    #1;
    n_cmp++;
    if (a_rd_data !== 64'd0) begin
      n_err++; $display("FAIL reset_mid_rd got=%h exp=0", a_rd_data);
    end
    n_cmp++;
    if (a_wr_count !== 16'd0) begin
      n_err++; $display("FAIL reset_mid_cnt got=%0d exp=0", a_wr_count);
    end
  endtask

  task automatic test_param();
    b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = 16'hA5A5; step();
    b_wr_addr = 3'd7; b_wr_data = 16'h0001; step();
    b_wr_en = 1'b0;
    b_rd_addr = {3'd0, 3'd7, 3'd0};
    #1;
    n_cmp++;
    if (b_rd_data !== {16'hA5A5, 16'h0001, 16'hA5A5}) begin
      n_err++; $display("FAIL param_rd got=%h exp=%h", b_rd_data, {16'hA5A5, 16'h0001, 16'hA5A5});
    end
    n_cmp++;
    if (b_wr_count !== 16'd2) begin
      n_err++; $display("FAIL param_cnt got=%0d exp=2", b_wr_count);
    end
    b_rd_addr = {3'd5, 3'd5, 3'd7};
    #1;
    n_cmp++;
    if (b_rd_data !== {16'h0000, 16'h0000, 16'h0001}) begin
      n_err++; $display("FAIL param_rd2 got=%h exp=%h", b_rd_data, {16'h0000, 16'h0000, 16'h0001});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
